// File: rtl/cmd_dispatch_queue.sv
// cmd_dispatch_queue
//   Collects commands from NCH source channels through a round-robin arbiter,
//   stores well-formed ones in a 2^DEPTH_LOG2-entry FIFO, and presents the
//   head entry to a list engine through a two-state exec FSM.
//
// Ports
//   aclk, areset            clock, asynchronous active-high reset
//   req_valid_in[NCH]       per-channel request, held until accepted
//   req_op_in[4*NCH]        per-channel one-hot op (slice c = bits 4c+3:4c)
//   req_payload_in[..]      per-channel payload (slice c)
//   req_ready_out[NCH]      combinational accept strobe, at most one bit set
//   exec_valid_out/op/payload  head command while the FSM is in EXEC
//   exec_done_in            completion pulse from the list engine
//   count_out, full_out, empty_out  FIFO occupancy
//   drop_count_out          saturating count of rejected (non-one-hot) ops
//
// Exec FSM
//   state  | meaning
//   S_IDLE | nothing presented; waits for a non-empty queue
//   S_EXEC | head entry presented; waits for exec_done_in, then pops
module cmd_dispatch_queue #(
  parameter int NCH        = 4,
  parameter int DEPTH_LOG2 = 4,
  parameter int PAYLOAD_W  = 38
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NCH-1:0]            req_valid_in,
  input  logic [4*NCH-1:0]          req_op_in,
  input  logic [PAYLOAD_W*NCH-1:0]  req_payload_in,
  output logic [NCH-1:0]            req_ready_out,
  output logic                      exec_valid_out,
  output logic [3:0]                exec_op_out,
  output logic [PAYLOAD_W-1:0]      exec_payload_out,
  input  logic                      exec_done_in,
  output logic [DEPTH_LOG2:0]       count_out,
  output logic                      full_out,
  output logic                      empty_out,
  output logic [15:0]               drop_count_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int RR_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int ENT_W = 4 + PAYLOAD_W;

  typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ENT_W-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2:0]   r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_rd_ptr;
  logic [RR_W-1:0]       r_rr_ptr;
  logic [15:0]           r_drop_cnt;

  logic                  w_grant_vld;
  logic [RR_W-1:0]       w_grant_idx;
  logic [3:0]            w_grant_op;
  logic [PAYLOAD_W-1:0]  w_grant_pl;
  logic                  w_op_ok;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic [ENT_W-1:0]      w_head;

  // Pointers carry one extra MSB, so the difference is the occupancy directly.
  assign count_out      = r_wr_ptr - r_rd_ptr;
  assign full_out       = (count_out == (DEPTH_LOG2+1)'(DEPTH));
  assign empty_out      = (count_out == '0);
  assign drop_count_out = r_drop_cnt;

  // Round-robin search from r_rr_ptr: scanning offsets high to low lets the
  // lowest offset with a request win. No grant while full or in reset.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_valid_in[(int'(r_rr_ptr) + i) % NCH]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = RR_W'((int'(r_rr_ptr) + i) % NCH);
      end
    end
    if (full_out || areset) w_grant_vld = 1'b0;
  end

  assign w_grant_op    = req_op_in[int'(w_grant_idx)*4 +: 4];
  assign w_grant_pl    = req_payload_in[int'(w_grant_idx)*PAYLOAD_W +: PAYLOAD_W];
  assign w_op_ok       = $onehot(w_grant_op);
  assign w_push        = w_grant_vld && w_op_ok;
  assign w_drop        = w_grant_vld && !w_op_ok;
  assign w_pop         = (r_state == S_EXEC) && exec_done_in;
  assign req_ready_out = w_grant_vld ? (NCH'(1) << w_grant_idx) : '0;

  // Storage is deliberately left out of reset.
  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= {w_grant_op, w_grant_pl};
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rr_ptr   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      // Rejected requests are still grants, so they advance the pointer too.
      if (w_grant_vld)
        r_rr_ptr <= (w_grant_idx == RR_W'(NCH - 1)) ? '0 : w_grant_idx + 1'b1;
      if (w_drop && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!empty_out)   w_state_nxt = S_EXEC;
      S_EXEC:  if (exec_done_in) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The read pointer only moves on the edge that leaves EXEC, so the head
  // stays stable for the whole state.
  assign w_head = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

  always_comb begin
    exec_valid_out   = 1'b0;
    exec_op_out      = '0;
    exec_payload_out = '0;
    if (r_state == S_EXEC) begin
      exec_valid_out   = 1'b1;
      exec_op_out      = w_head[ENT_W-1 -: 4];
      exec_payload_out = w_head[PAYLOAD_W-1:0];
    end
  end

endmodule

// File: tb/tb_cmd_dispatch_queue.sv
module tb_cmd_dispatch_queue;

  localparam int NCH = 4;
  localparam int DL  = 2;
  localparam int PW  = 38;

  logic              aclk = 1'b0;
  logic              areset;
  logic [NCH-1:0]    req_valid_in;
  logic [4*NCH-1:0]  req_op_in;
  logic [PW*NCH-1:0] req_payload_in;
  logic [NCH-1:0]    req_ready_out;
  logic              exec_valid_out;
  logic [3:0]        exec_op_out;
  logic [PW-1:0]     exec_payload_out;
  logic              exec_done_in;
  logic [DL:0]       count_out;
  logic              full_out;
  logic              empty_out;
  logic [15:0]       drop_count_out;

  int total = 0;
  int bad   = 0;

  cmd_dispatch_queue #(.NCH(NCH), .DEPTH_LOG2(DL), .PAYLOAD_W(PW)) dut (
    .aclk             (aclk),
    .areset           (areset),
    .req_valid_in     (req_valid_in),
    .req_op_in        (req_op_in),
    .req_payload_in   (req_payload_in),
    .req_ready_out    (req_ready_out),
    .exec_valid_out   (exec_valid_out),
    .exec_op_out      (exec_op_out),
    .exec_payload_out (exec_payload_out),
    .exec_done_in     (exec_done_in),
    .count_out        (count_out),
    .full_out         (full_out),
    .empty_out        (empty_out),
    .drop_count_out   (drop_count_out)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request on a single channel, wait (bounded) for its grant,
  // take the accepting edge and withdraw it.
  task automatic push(input int ch, input logic [3:0] op, input logic [PW-1:0] pl);
    int n;
    n = 0;
    req_valid_in[ch]            = 1'b1;
    req_op_in[ch*4 +: 4]        = op;
    req_payload_in[ch*PW +: PW] = pl;
    #1;
    while (req_ready_out[ch] !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    chk("push_ready", 64'(req_ready_out[ch]), 64'd1);
    step();
    req_valid_in[ch] = 1'b0;
  endtask

  // Wait (bounded) for the head, check it, complete it, check the IDLE gap.
  task automatic pop_expect(input logic [PW-1:0] pl, input logic [3:0] op);
    int n;
    n = 0;
    while (exec_valid_out !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk("pop_valid", 64'(exec_valid_out), 64'd1);
    chk("pop_payload", 64'(exec_payload_out), 64'(pl));
    chk("pop_op", 64'(exec_op_out), 64'(op));
    exec_done_in = 1'b1;
    step();
    exec_done_in = 1'b0;
    chk("pop_idle_gap", 64'(exec_valid_out), 64'd0);
  endtask

  initial begin
    areset         = 1'b1;
    req_valid_in   = '0;
    req_op_in      = '0;
    req_payload_in = '0;
    exec_done_in   = 1'b0;
    step();
    step();
    chk("rst_empty", 64'(empty_out), 64'd1);
    chk("rst_full", 64'(full_out), 64'd0);
    chk("rst_count", 64'(count_out), 64'd0);
    chk("rst_valid", 64'(exec_valid_out), 64'd0);
    chk("rst_ready", 64'(req_ready_out), 64'd0);
    chk("rst_drop", 64'(drop_count_out), 64'd0);
    areset = 1'b0;
    step();

    // Round-robin over four held requests, payloads 0..3.
    req_op_in = {4{4'b0010}};
    for (int c = 0; c < NCH; c++) req_payload_in[c*PW +: PW] = PW'(c);
    req_valid_in = 4'hF;
    #1;
    chk("rr_grant0", 64'(req_ready_out), 64'b0001);
    step();
    chk("rr_count1", 64'(count_out), 64'd1);
    chk("rr_lat_idle", 64'(exec_valid_out), 64'd0);
    chk("rr_grant1", 64'(req_ready_out), 64'b0010);
    step();
    chk("rr_count2", 64'(count_out), 64'd2);
    chk("rr_lat_exec", 64'(exec_valid_out), 64'd1);
    chk("rr_head0", 64'(exec_payload_out), 64'd0);
    chk("rr_grant2", 64'(req_ready_out), 64'b0100);
    step();
    chk("rr_count3", 64'(count_out), 64'd3);
    chk("rr_grant3", 64'(req_ready_out), 64'b1000);
    step();
    chk("rr_count4", 64'(count_out), 64'd4);
    chk("rr_full", 64'(full_out), 64'd1);
    chk("rr_full_noready", 64'(req_ready_out), 64'd0);
    req_valid_in = '0;
    for (int c = 0; c < NCH; c++) pop_expect(PW'(c), 4'b0010);
    chk("rr_drained", 64'(empty_out), 64'd1);

    // Fill to full, fifth request blocked until the first completion.
    push(0, 4'b0010, 38'h10);
    push(1, 4'b0010, 38'h11);
    push(2, 4'b0010, 38'h12);
    push(3, 4'b0010, 38'h13);
    chk("full_count", 64'(count_out), 64'd4);
    chk("full_flag", 64'(full_out), 64'd1);
    chk("full_head", 64'(exec_payload_out), 64'h10);
    req_valid_in[2]          = 1'b1;
    req_op_in[8 +: 4]        = 4'b0100;
    req_payload_in[2*PW +: PW] = 38'h14;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("full_blocked", 64'(req_ready_out), 64'd0);
      step();
    end
    exec_done_in = 1'b1;
    #1;
    chk("full_pop_noready", 64'(req_ready_out), 64'd0);
    step();
    exec_done_in = 1'b0;
    chk("full_after_pop_cnt", 64'(count_out), 64'd3);
    chk("full_after_pop_flag", 64'(full_out), 64'd0);
    chk("full_fifth_ready", 64'(req_ready_out), 64'b0100);
    step();
    req_valid_in[2] = 1'b0;
    chk("full_refill", 64'(count_out), 64'd4);
    pop_expect(38'h11, 4'b0010);
    pop_expect(38'h12, 4'b0010);
    pop_expect(38'h13, 4'b0010);
    pop_expect(38'h14, 4'b0100);
    chk("full_drained", 64'(empty_out), 64'd1);

    // Malformed op: consumed, not stored, counted, saturating.
    req_valid_in[1]   = 1'b1;
    req_op_in[4 +: 4] = 4'b0011;
    #1;
    chk("bad_ready", 64'(req_ready_out), 64'b0010);
    step();
    chk("bad_count", 64'(count_out), 64'd0);
    chk("bad_drop1", 64'(drop_count_out), 64'd1);
    chk("bad_noexec", 64'(exec_valid_out), 64'd0);
    for (int i = 0; i < 65533; i++) @(posedge aclk);
    #1;
    chk("bad_drop_fffe", 64'(drop_count_out), 64'hFFFE);
    step();
    chk("bad_drop_ffff", 64'(drop_count_out), 64'hFFFF);
    step();
    step();
    chk("bad_drop_sat", 64'(drop_count_out), 64'hFFFF);
    chk("bad_count_end", 64'(count_out), 64'd0);
    req_valid_in[1] = 1'b0;
    step();

    // Pop and push on the same edge.
    push(0, 4'b0001, 38'h20);
    push(1, 4'b0001, 38'h21);
    chk("pp_count2", 64'(count_out), 64'd2);
    chk("pp_head", 64'(exec_payload_out), 64'h20);
    req_valid_in[3]            = 1'b1;
    req_op_in[12 +: 4]         = 4'b1000;
    req_payload_in[3*PW +: PW] = 38'h22;
    exec_done_in               = 1'b1;
    #1;
    chk("pp_ready", 64'(req_ready_out), 64'b1000);
    step();
    req_valid_in[3] = 1'b0;
    exec_done_in    = 1'b0;
    chk("pp_count_same", 64'(count_out), 64'd2);
    chk("pp_idle", 64'(exec_valid_out), 64'd0);
    step();
    chk("pp_next_valid", 64'(exec_valid_out), 64'd1);
    chk("pp_next_head", 64'(exec_payload_out), 64'h21);
    pop_expect(38'h21, 4'b0001);
    pop_expect(38'h22, 4'b1000);

    // Sixteen push/pop rounds to wrap both pointers.
    for (int i = 0; i < 16; i++) begin
      push(i % NCH, 4'b0001, PW'(32'h100 + i));
      chk("wrap_count", 64'(count_out), 64'd1);
      chk("wrap_flags", 64'({full_out, empty_out}), 64'b00);
      pop_expect(PW'(32'h100 + i), 4'b0001);
    end
    chk("wrap_empty", 64'({full_out, empty_out}), 64'b01);
    chk("wrap_count0", 64'(count_out), 64'd0);

    // Reset in the middle of EXEC with three queued.
    push(0, 4'b0001, 38'h30);
    push(1, 4'b0001, 38'h31);
    push(2, 4'b0001, 38'h32);
    chk("mr_count3", 64'(count_out), 64'd3);
    chk("mr_exec", 64'(exec_valid_out), 64'd1);
    req_valid_in[3]            = 1'b1;
    req_op_in[12 +: 4]         = 4'b0001;
    req_payload_in[3*PW +: PW] = 38'h7;
    #1;
    chk("mr_ready_pre", 64'(req_ready_out), 64'b1000);
    #1;
    areset = 1'b1;
    #1;
    chk("mr_valid", 64'(exec_valid_out), 64'd0);
    chk("mr_payload", 64'(exec_payload_out), 64'd0);
    chk("mr_count", 64'(count_out), 64'd0);
    chk("mr_flags", 64'({full_out, empty_out}), 64'b01);
    chk("mr_ready", 64'(req_ready_out), 64'd0);
    chk("mr_drop", 64'(drop_count_out), 64'd0);
    req_valid_in = '0;
    step();
    step();
    areset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_quiet", 64'(exec_valid_out), 64'd0);
    end
    push(0, 4'b0001, 38'h5);
    chk("mr_post_count", 64'(count_out), 64'd1);
    pop_expect(38'h5, 4'b0001);
    chk("mr_post_empty", 64'(empty_out), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_dispatch_queue.md
CMD_DISPATCH_QUEUE -- requirements
Module: cmd_dispatch_queue

Interface
REQ-001 Parameter NCH, default 4: number of command source channels, range 1..8.
REQ-002 Parameter DEPTH_LOG2, default 4: queue depth is 2^DEPTH_LOG2 entries.
REQ-003 Parameter PAYLOAD_W, default 38: per-command payload width, e.g. {tcb address 32, priority 6} or {id 8, zero-padded}.
REQ-004 aclk  in  1  sole clock; all state updates on the rising edge.
REQ-005 areset  in  1  asynchronous, active-high reset.
REQ-006 req_valid_in  in  NCH  per-channel command request, held until accepted.
REQ-007 req_op_in  in  4*NCH  per-channel one-hot op: 0001 insert-new, 0010 ready, 0100 suspend, 1000 delete; channel c uses bits [4c+3:4c].
REQ-008 req_payload_in  in  PAYLOAD_W*NCH  per-channel payload; channel c uses slice c.
REQ-009 req_ready_out  out  NCH  combinational accept strobe; at most one bit high per cycle.
REQ-010 exec_valid_out  out  1  head command presented to the list engine.
REQ-011 exec_op_out  out  4  head op, one-hot.
REQ-012 exec_payload_out  out  PAYLOAD_W  head payload.
REQ-013 exec_done_in  in  1  single-cycle pulse from the list engine: current command completed.
REQ-014 count_out  out  DEPTH_LOG2+1  number of stored entries.
REQ-015 full_out / empty_out  out  1 each  count_out == 2^DEPTH_LOG2 / count_out == 0.
REQ-016 drop_count_out  out  16  saturating count of rejected malformed requests.

Function
REQ-017 Arbitration: round-robin across channels with req_valid_in high; search starts at rr_ptr; rr_ptr resets to 0.
REQ-018 On a grant to channel g, rr_ptr becomes (g+1) mod NCH on the next edge; with no grant, rr_ptr holds.
REQ-019 A grant requires full_out == 0; when full_out == 1, req_ready_out stays all-zero. A pop in the same cycle does not enable a push.
REQ-020 A granted request with a well-formed one-hot op writes {op, payload} at the write pointer; the write pointer and count_out update on the same edge.
REQ-021 A granted request with an op that is not one-hot still asserts req_ready_out and is consumed, but is not written.
REQ-022 For such a rejected request, drop_count_out increments by 1 and saturates at 16'hFFFF.
REQ-023 Pointers are DEPTH_LOG2+1 bits wide and wrap modulo 2^(DEPTH_LOG2+1). The extra MSB distinguishes full from empty.
REQ-024 Exec FSM has two states. IDLE moves to EXEC on an edge where empty_out == 0. EXEC moves to IDLE on an edge where exec_done_in == 1.
REQ-025 In EXEC, exec_valid_out = 1, and exec_op_out/exec_payload_out show the entry at the read pointer, stable for the whole state. In IDLE, exec_valid_out = 0 and both fields are 0.
REQ-026 exec_done_in in EXEC pops the head: the read pointer advances and count_out decrements on that edge.
REQ-027 exec_done_in in IDLE is ignored.
REQ-028 Simultaneous push and pop on one edge leave count_out unchanged; both pointers advance.
REQ-029 Latency: a command accepted at edge k into an empty queue, with the FSM in IDLE, gives exec_valid_out = 1 after edge k+1.
REQ-030 After a pop, at least one IDLE cycle separates consecutive commands.
REQ-031 Commands execute strictly in acceptance order; no command is lost or duplicated.

Reset
REQ-032 areset clears the pointers, count_out (0), rr_ptr (0), drop_count_out (0) and the FSM (IDLE); empty_out = 1, full_out = 0, exec_valid_out = 0, req_ready_out = 0.
REQ-033 Storage contents are not reset.
REQ-034 areset asserted mid-EXEC abandons the in-flight command and all queued commands. No exec_valid_out is produced until new commands arrive after reset deasserts.

Verification
REQ-035 NCH=4; channels 0..3 all valid with op 0010 and payloads 0..3 for 4 cycles -> grants in order 0,1,2,3; exec_payload_out sequence 0,1,2,3.
REQ-036 DEPTH_LOG2=2 with no exec_done_in; push 5 commands -> count_out reaches 4 and full_out = 1; 5th channel sees req_ready_out = 0 until the first exec_done_in; then the 5th is accepted and executes last.
REQ-037 Channel 1 requests op 0011 -> req_ready_out[1] = 1, count_out unchanged, drop_count_out = 1; forcing 65536 more rejects -> drop_count_out stays 16'hFFFF.
REQ-038 Queue at count 2 in EXEC; exec_done_in and a new push on the same edge -> count_out stays 2; the next head appears after one IDLE cycle.
REQ-039 16 push/pop cycles at DEPTH_LOG2=2 -> pointers wrap correctly, full_out/empty_out match count_out, FIFO order preserved.
REQ-040 areset pulsed while exec_valid_out = 1 with count 3 -> all outputs return to reset values immediately; a post-reset push with payload 38'h5 executes as the first command.
